// File: rtl/mem_bus_bridge.sv
// Memory-map bridge behind the control unit: latches the multiplexed address on ALE,
// then performs one RAM access or one I/O register access per strobe.
module mem_bus_bridge #(
    parameter int          DATA_W  = 16,
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] IO_BASE = 16'h8000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] SysBusIn,
    output logic [DATA_W-1:0] SysBusOut,
    output logic              SysBusOe,
    input  logic              ALE,
    input  logic              nME,
    input  logic              nOE,
    input  logic              nWE,
    output logic [RAM_AW-1:0] RamAddr,
    output logic [DATA_W-1:0] RamWData,
    output logic              RamWe,
    output logic              RamRe,
    input  logic [DATA_W-1:0] RamRData,
    input  logic [15:0]       Switches,
    output logic [15:0]       Leds,
    output logic              TimerMatch,
    output logic [2:0]        DebugState
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_WR_DONE = 3'd4;

    // Bus handshake: an access is ALE (address phase) followed by a strobe held
    // for one or more cycles; the bridge has no ready, so reads must be on the
    // bus from the cycle after the strobe starts and writes commit on its first cycle.

    logic [2:0]        state;
    logic [15:0]       addrLatch;
    logic [DATA_W-1:0] rdBuf;
    logic [15:0]       timer;
    logic [15:0]       compare;
    logic [15:0]       swMeta;
    logic [15:0]       swSync;

    logic        readStb;
    logic        writeStb;
    logic        isIo;
    logic        inAddr;
    logic        ioWrite;
    logic        ioRead;
    logic        dataPhase;
    logic [15:0] ioOffset;
    logic [15:0] ioRdValue;
    logic        timerClear;
    logic [15:0] timerNext;

    assign readStb   = !nME && !nOE && nWE;
    assign writeStb  = !nME && !nWE;
    assign isIo      = addrLatch[15];
    assign ioOffset  = addrLatch - IO_BASE;
    // A same-cycle ALE abandons the access, so no commit happens on that edge.
    assign inAddr    = (state == ST_ADDR) && !ALE;
    assign ioWrite   = inAddr && writeStb && isIo;
    assign ioRead    = inAddr && readStb && isIo;
    assign dataPhase = (state == ST_RD_REQ) || (state == ST_RD_DATA);

    assign RamAddr    = addrLatch[RAM_AW-1:0];
    assign RamWData   = SysBusIn;
    assign RamWe      = inAddr && writeStb && !isIo;
    assign RamRe      = inAddr && readStb && !isIo;
    assign SysBusOe   = dataPhase && readStb;
    assign DebugState = state;

    always_comb begin
        SysBusOut = '0;
        if (SysBusOe) begin
            if ((state == ST_RD_REQ) && !isIo)
                SysBusOut = RamRData;
            else
                SysBusOut = rdBuf;
        end
    end

    always_comb begin
        ioRdValue = 16'h0000;
        case (ioOffset)
            16'd0:   ioRdValue = Leds;
            16'd1:   ioRdValue = swSync;
            16'd2:   ioRdValue = timer;
            16'd3:   ioRdValue = compare;
            16'd4:   ioRdValue = {15'd0, TimerMatch};
            default: ioRdValue = 16'h0000;
        endcase
    end

    assign timerClear = ioWrite && (ioOffset == 16'd2);
    assign timerNext  = timerClear ? 16'h0000 : timer + 16'd1;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            addrLatch <= '0;
            rdBuf     <= '0;
        end else begin
            if (ALE) begin
                addrLatch <= SysBusIn[15:0];
                state     <= ST_ADDR;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_IDLE;
                    ST_ADDR: begin
                        if (nME)           state <= ST_IDLE;
                        else if (readStb)  state <= ST_RD_REQ;
                        else if (writeStb) state <= ST_WR_DONE;
                    end
                    ST_RD_REQ:  state <= nME ? ST_IDLE : ST_RD_DATA;
                    ST_RD_DATA: if (nME) state <= ST_IDLE;
                    ST_WR_DONE: if (nME) state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end
            // RAM data is only valid for one cycle, so hold it for the rest of the strobe.
            if (ioRead)
                rdBuf <= DATA_W'(ioRdValue);
            else if ((state == ST_RD_REQ) && !isIo && readStb && !ALE)
                rdBuf <= RamRData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Leds       <= 16'h0000;
            compare    <= 16'h0000;
            timer      <= 16'h0000;
            TimerMatch <= 1'b0;
            swMeta     <= 16'h0000;
            swSync     <= 16'h0000;
        end else begin
            swMeta <= Switches;
            swSync <= swMeta;
            timer  <= timerNext;
            if (ioWrite && (ioOffset == 16'd0)) Leds    <= SysBusIn[15:0];
            if (ioWrite && (ioOffset == 16'd3)) compare <= SysBusIn[15:0];
            // The flag rises together with Timer reaching Compare; a set beats a clear.
            if (timerNext == compare)
                TimerMatch <= 1'b1;
            else if (ioWrite && (ioOffset == 16'd4) && SysBusIn[0])
                TimerMatch <= 1'b0;
        end
    end

endmodule
